regfile_dbg_port: RTL and testbench
===================================

# regfile_dbg_port

Debug-side initiator for the CPU register file. It sits between the core's operand/writeback port and the register file, and forwards core traffic unchanged while the core runs. While the core is halted, it accepts debug commands (read one register, write one register, clear all registers) over a valid/ready handshake. It sequences each command onto the register file's read/write port and returns results.

## Interface
- REG_FILE_SIZE, 32, number of architectural registers (r0 hardwired zero in regfile)
- REG_FILE_WIDTH, 32, register data width
- I_clk  in  1  clock
- I_rstn  in  1  asynchronous, active-low reset
- I_halt  in  1  core halted; debug access permitted only when 1
- I_core_rs1, I_core_rs2, I_core_rd  in  5 each  core register indices
- I_core_re, I_core_we  in  1 each  core read/write enables
- I_core_data  in  REG_FILE_WIDTH  core writeback data
- I_dbg_valid  in  1  debug command valid
- O_dbg_ready  out  1  debug command accept
- I_dbg_cmd  in  2  00 read, 01 write, 10 clear-all, 11 illegal
- I_dbg_addr  in  5  target register
- I_dbg_wdata  in  REG_FILE_WIDTH  write data
- O_dbg_rvalid  out  1  one-cycle pulse, read data valid
- O_dbg_rdata  out  REG_FILE_WIDTH  read data, held until next read completes
- O_dbg_done  out  1  one-cycle pulse, write/clear/illegal command complete
- O_dbg_err  out  1  qualifies O_dbg_done; 1 = illegal cmd or I_dbg_addr ≥ REG_FILE_SIZE
- O_rf_rs1, O_rf_rs2, O_rf_rd  out  5 each  to regfile
- O_rf_re, O_rf_we  out  1 each  to regfile
- O_rf_data  out  REG_FILE_WIDTH  to regfile write data
- I_rf_regval1  in  REG_FILE_WIDTH  regfile port-1 read data (registered in regfile, valid the cycle after re)

## Operation
- States: IDLE, RD, RDW, WR, CLR, ERR.
- IDLE: O_rf_* = core inputs, except O_rf_we = I_core_we & ~I_halt. O_dbg_ready = I_halt.
- Accept on I_dbg_valid & O_dbg_ready.
  - read → RD
  - write → WR
  - clear → CLR with counter = 1
  - cmd 11 or addr out of range → ERR
- RD: O_rf_re=1, rs1=rs2=addr, we=0. Next state is RDW.
- RDW: re=we=0. Capture I_rf_regval1 into O_dbg_rdata. Next state is IDLE with O_dbg_rvalid=1.
- WR: O_rf_we=1, rd=addr, data=wdata. Next state is IDLE with O_dbg_done=1. A write to r0 completes normally; the regfile drops it.
- CLR: O_rf_we=1, rd=counter, data=0. The counter increments. After counter = REG_FILE_SIZE-1, next state is IDLE with O_dbg_done=1.
- ERR: no rf access. Next state is IDLE with O_dbg_done=1 and O_dbg_err=1.
- In all non-IDLE states, core inputs are ignored: no core re/we reaches the regfile.
- I_halt falling mid-command: the command runs to completion. Passthrough resumes in IDLE.
- Command fields are latched at accept. Changes on I_dbg_* afterwards have no effect.

## Timing
- Cycle 0 is the edge where the accept is sampled.
- Read: RD in cycle 1, RDW in cycle 2, O_dbg_rvalid and O_dbg_rdata in cycle 3.
- Write: rf write in cycle 1, O_dbg_done in cycle 2.
- Clear: rf writes in cycles 1..REG_FILE_SIZE-1, O_dbg_done in cycle REG_FILE_SIZE (32 for the default).
- Error: O_dbg_done with O_dbg_err in cycle 2.
- O_dbg_ready is 0 from cycle 1 through the last non-IDLE cycle. It is 1 in the pulse cycle, so back-to-back accept is allowed.
- Reset (I_rstn=0), asynchronous, at any point including mid-clear:
  - state goes to IDLE, counter to 0
  - O_dbg_rdata=0
  - O_dbg_rvalid, O_dbg_done, O_dbg_err = 0
  - O_dbg_ready follows I_halt
  - registers not yet cleared keep their contents
- Pulse outputs and O_dbg_rdata are registered. O_rf_* and O_dbg_ready are combinational from state, latched fields and core inputs.

## Structure
- Shared package regfile_dbg_pkg contains:
  - command encodings (DBG_CMD_READ/WRITE/CLEAR/ILLEGAL)
  - state enum
  - REG_IDX_WIDTH = 5
- No sub-module. The passthrough mux, FSM, command latch and clear counter live in one module.

## Test plan
- Halt=1; write r5=0xDEADBEEF; read r5 → O_dbg_done in cycle 2 of the write; O_dbg_rvalid in cycle 3 of the read with O_dbg_rdata=0xDEADBEEF.
- Write r0=0x00001234, then read r0 → O_dbg_err=0 on the write's done; read returns 0x00000000.
- Preload r1=0x1, r31=0xFFFFFFFF; clear-all → O_rf_we high in cycles 1..31 with rd 1..31; O_dbg_done in cycle 32; O_dbg_ready=0 throughout; subsequent reads of r1 and r31 return 0.
- I_halt=0 with I_dbg_valid=1 held → O_dbg_ready=0 and no accept; core we to r7=0x55 passes through and reads back 0x55. Raise halt → accept on next edge.
- Reset pulse while in CLR at counter=10 → outputs return to reset values immediately; r1..r9 (already written) read 0; r10..r31 keep their preloaded values.
- cmd=11, then cmd=read with addr beyond size (REG_FILE_SIZE=16 build, addr=20) → each gives O_dbg_done=O_dbg_err=1 in cycle 2; O_rf_re=O_rf_we=0 throughout.

Source files
------------

// File: rtl/regfile_dbg_pkg.sv
// Shared definitions for the register-file debug port.
// Contents:
//   REG_IDX_WIDTH : width of a register index
//   dbg_cmd_t     : debug command encodings
//   dbg_state_t   : sequencer states
package regfile_dbg_pkg;

   localparam int REG_IDX_WIDTH = 5;

   typedef enum logic [1:0] {
      DBG_CMD_READ    = 2'b00,
      DBG_CMD_WRITE   = 2'b01,
      DBG_CMD_CLEAR   = 2'b10,
      DBG_CMD_ILLEGAL = 2'b11
   } dbg_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RDW,
      ST_WR,
      ST_CLR,
      ST_ERR
   } dbg_state_t;

endpackage

// File: rtl/regfile_dbg_port_if.sv
// Debug command/response bundle of the register-file debug port.
// Signals (named from the port's point of view):
//   I_dbg_valid/O_dbg_ready : command handshake
//   I_dbg_cmd/addr/wdata    : command fields
//   O_dbg_rvalid/O_dbg_rdata: read response (pulse + held data)
//   O_dbg_done/O_dbg_err    : write/clear/illegal completion pulse + error flag
// Modports: master = debugger side, slave = debug port side.
interface regfile_dbg_port_if #(
   parameter int REG_FILE_WIDTH = 32
);
   import regfile_dbg_pkg::*;

   logic                      I_dbg_valid;
   logic                      O_dbg_ready;
   logic [1:0]                I_dbg_cmd;
   logic [REG_IDX_WIDTH-1:0]  I_dbg_addr;
   logic [REG_FILE_WIDTH-1:0] I_dbg_wdata;
   logic                      O_dbg_rvalid;
   logic [REG_FILE_WIDTH-1:0] O_dbg_rdata;
   logic                      O_dbg_done;
   logic                      O_dbg_err;

   modport master (
      output I_dbg_valid, I_dbg_cmd, I_dbg_addr, I_dbg_wdata,
      input  O_dbg_ready, O_dbg_rvalid, O_dbg_rdata, O_dbg_done, O_dbg_err
   );

   modport slave (
      input  I_dbg_valid, I_dbg_cmd, I_dbg_addr, I_dbg_wdata,
      output O_dbg_ready, O_dbg_rvalid, O_dbg_rdata, O_dbg_done, O_dbg_err
   );

endinterface

// File: rtl/regfile_dbg_port.sv
// Debug-side initiator for the CPU register file.
// Passes core operand/writeback traffic straight to the register file while
// idle; while the core is halted it accepts read/write/clear-all commands on
// the debug interface and sequences them onto the register-file port.
// Ports:
//   I_clk, I_rstn          : clock, asynchronous active-low reset
//   I_halt                 : core halted (debug accepts only when 1)
//   I_core_*               : core register-file request
//   dbg                    : debug command/response interface (slave)
//   O_rf_*                 : request to the register file
//   I_rf_regval1           : register-file port-1 read data (one cycle after re)
module regfile_dbg_port
   import regfile_dbg_pkg::*;
#(
   parameter int REG_FILE_SIZE  = 32,
   parameter int REG_FILE_WIDTH = 32
) (
   input  logic                      I_clk,
   input  logic                      I_rstn,
   input  logic                      I_halt,
   input  logic [REG_IDX_WIDTH-1:0]  I_core_rs1,
   input  logic [REG_IDX_WIDTH-1:0]  I_core_rs2,
   input  logic [REG_IDX_WIDTH-1:0]  I_core_rd,
   input  logic                      I_core_re,
   input  logic                      I_core_we,
   input  logic [REG_FILE_WIDTH-1:0] I_core_data,
   regfile_dbg_port_if.slave         dbg,
   output logic [REG_IDX_WIDTH-1:0]  O_rf_rs1,
   output logic [REG_IDX_WIDTH-1:0]  O_rf_rs2,
   output logic [REG_IDX_WIDTH-1:0]  O_rf_rd,
   output logic                      O_rf_re,
   output logic                      O_rf_we,
   output logic [REG_FILE_WIDTH-1:0] O_rf_data,
   input  logic [REG_FILE_WIDTH-1:0] I_rf_regval1
);

   // Last register written by clear-all (r0 is hardwired, so clearing starts at 1).
   localparam logic [REG_IDX_WIDTH-1:0] CLR_LAST = REG_IDX_WIDTH'(REG_FILE_SIZE - 1);

   dbg_state_t                r_state;
   dbg_state_t                w_state_next;
   logic [REG_IDX_WIDTH-1:0]  r_cnt;
   logic [REG_IDX_WIDTH-1:0]  w_cnt_next;
   logic [REG_IDX_WIDTH-1:0]  r_addr;
   logic [REG_FILE_WIDTH-1:0] r_wdata;
   logic [REG_FILE_WIDTH-1:0] r_rdata;
   logic [REG_FILE_WIDTH-1:0] w_rdata_next;
   logic                      r_rvalid;
   logic                      w_rvalid_next;
   logic                      r_done;
   logic                      w_done_next;
   logic                      r_err;
   logic                      w_err_next;

   logic                      w_ready;
   logic                      w_accept;
   logic                      w_addr_oob;
   logic                      w_cmd_err;
   dbg_cmd_t                  w_cmd;

   assign w_cmd      = dbg_cmd_t'(dbg.I_dbg_cmd);
   assign w_ready    = (r_state == ST_IDLE) & I_halt;
   assign w_accept   = dbg.I_dbg_valid & w_ready;
   assign w_addr_oob = (32'(dbg.I_dbg_addr) >= 32'(REG_FILE_SIZE));
   assign w_cmd_err  = (w_cmd == DBG_CMD_ILLEGAL) | w_addr_oob;

   assign dbg.O_dbg_ready  = w_ready;
   assign dbg.O_dbg_rvalid = r_rvalid;
   assign dbg.O_dbg_rdata  = r_rdata;
   assign dbg.O_dbg_done   = r_done;
   assign dbg.O_dbg_err    = r_err;

   always_ff @(posedge I_clk or negedge I_rstn) begin
      if (!I_rstn) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_rdata  <= w_rdata_next;
         r_rvalid <= w_rvalid_next;
         r_done   <= w_done_next;
         r_err    <= w_err_next;
         // Fields are captured once; later changes on the bus are ignored.
         if (w_accept) begin
            r_addr  <= dbg.I_dbg_addr;
            r_wdata <= dbg.I_dbg_wdata;
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_rdata_next  = r_rdata;
      w_rvalid_next = 1'b0;
      w_done_next   = 1'b0;
      w_err_next    = 1'b0;
      // Index/data fields follow the core by default; only the enables gate access.
      O_rf_rs1      = I_core_rs1;
      O_rf_rs2      = I_core_rs2;
      O_rf_rd       = I_core_rd;
      O_rf_data     = I_core_data;
      O_rf_re       = 1'b0;
      O_rf_we       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            O_rf_re = I_core_re;
            // A halted core must not disturb registers the debugger is inspecting.
            O_rf_we = I_core_we & ~I_halt;
            if (w_accept) begin
               if (w_cmd_err) begin
                  w_state_next = ST_ERR;
               end else begin
                  case (w_cmd)
                     DBG_CMD_READ:  w_state_next = ST_RD;
                     DBG_CMD_WRITE: w_state_next = ST_WR;
                     default: begin
                        w_state_next = ST_CLR;
                        w_cnt_next   = REG_IDX_WIDTH'(1);
                     end
                  endcase
               end
            end
         end
         ST_RD: begin
            O_rf_re      = 1'b1;
            O_rf_rs1     = r_addr;
            O_rf_rs2     = r_addr;
            w_state_next = ST_RDW;
         end
         ST_RDW: begin
            // Register file read data is valid this cycle.
            w_rdata_next  = I_rf_regval1;
            w_rvalid_next = 1'b1;
            w_state_next  = ST_IDLE;
         end
         ST_WR: begin
            O_rf_we      = 1'b1;
            O_rf_rd      = r_addr;
            O_rf_data    = r_wdata;
            w_done_next  = 1'b1;
            w_state_next = ST_IDLE;
         end
         ST_CLR: begin
            O_rf_we    = 1'b1;
            O_rf_rd    = r_cnt;
            O_rf_data  = '0;
            w_cnt_next = r_cnt + REG_IDX_WIDTH'(1);
            if (r_cnt == CLR_LAST) begin
               w_cnt_next   = '0;
               w_done_next  = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         ST_ERR: begin
            w_done_next  = 1'b1;
            w_err_next   = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_dbg_port.sv
`timescale 1ns/1ps
module tb_regfile_dbg_port;
   import regfile_dbg_pkg::*;

   localparam int NI = 2;   // instance 0: 32 registers, instance 1: 16 registers
   localparam int W  = 32;
   localparam int K_RD = 0, K_WR = 1, K_CLR = 2, K_ERR = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        halt;
   logic [4:0]  core_rs1, core_rs2, core_rd;
   logic        core_re, core_we;
   logic [31:0] core_data;
   logic        dbg_valid;
   logic [1:0]  dbg_cmd;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;

   logic        o_ready [NI];
   logic        o_rvalid[NI];
   logic        o_done  [NI];
   logic        o_err   [NI];
   logic [31:0] o_rdata [NI];
   logic [4:0]  rf_rs1  [NI];
   logic [4:0]  rf_rs2  [NI];
   logic [4:0]  rf_rd   [NI];
   logic        rf_re   [NI];
   logic        rf_we   [NI];
   logic [31:0] rf_data [NI];
   logic [31:0] rf_q    [NI] = '{default: '0};
   logic [31:0] rf_mem  [NI][32] = '{default: '0};

   int errors = 0;
   int checks = 0;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int SZ = (gi == 0) ? 32 : 16;
      regfile_dbg_port_if #(.REG_FILE_WIDTH(W)) dif ();
      assign dif.I_dbg_valid = dbg_valid;
      assign dif.I_dbg_cmd   = dbg_cmd;
      assign dif.I_dbg_addr  = dbg_addr;
      assign dif.I_dbg_wdata = dbg_wdata;
      assign o_ready[gi]     = dif.O_dbg_ready;
      assign o_rvalid[gi]    = dif.O_dbg_rvalid;
      assign o_rdata[gi]     = dif.O_dbg_rdata;
      assign o_done[gi]      = dif.O_dbg_done;
      assign o_err[gi]       = dif.O_dbg_err;

      regfile_dbg_port #(.REG_FILE_SIZE(SZ), .REG_FILE_WIDTH(W)) u_dut (
         .I_clk       (clk),
         .I_rstn      (rstn),
         .I_halt      (halt),
         .I_core_rs1  (core_rs1),
         .I_core_rs2  (core_rs2),
         .I_core_rd   (core_rd),
         .I_core_re   (core_re),
         .I_core_we   (core_we),
         .I_core_data (core_data),
         .dbg         (dif),
         .O_rf_rs1    (rf_rs1[gi]),
         .O_rf_rs2    (rf_rs2[gi]),
         .O_rf_rd     (rf_rd[gi]),
         .O_rf_re     (rf_re[gi]),
         .O_rf_we     (rf_we[gi]),
         .O_rf_data   (rf_data[gi]),
         .I_rf_regval1(rf_q[gi])
      );
   end

   // Register file behind each port: r0 reads zero, registered port-1 read.
   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (rf_we[k] && rf_rd[k] != 5'd0) rf_mem[k][rf_rd[k]] <= rf_data[k];
         if (rf_re[k]) rf_q[k] <= (rf_rs1[k] == 5'd0) ? 32'd0 : rf_mem[k][rf_rs1[k]];
      end
   end

   // ---------------- behavioural reference model ----------------
   // A command accepted at edge 0 occupies cycles 1..len-1 and reports in cycle len.
   bit        m_active[NI];
   int        m_kind  [NI];
   int        m_t     [NI];
   int        m_len   [NI];
   bit [4:0]  m_addr  [NI];
   bit [31:0] m_wdata [NI];
   bit [31:0] m_rval  [NI];
   bit        e_rvalid[NI];
   bit        e_done  [NI];
   bit        e_err   [NI];
   bit [31:0] e_rdata [NI];
   bit [31:0] shadow  [NI][32];

   function automatic int size_of(int k);
      return (k == 0) ? 32 : 16;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NI; k++) begin
            m_active[k] = 1'b0;
            e_rvalid[k] = 1'b0;
            e_done[k]   = 1'b0;
            e_err[k]    = 1'b0;
            e_rdata[k]  = '0;
         end
      end else begin
         for (int k = 0; k < NI; k++) begin
            e_rvalid[k] = 1'b0;
            e_done[k]   = 1'b0;
            e_err[k]    = 1'b0;
            if (m_active[k]) begin
               if (m_kind[k] == K_WR && m_addr[k] != 0) shadow[k][m_addr[k]] = m_wdata[k];
               if (m_kind[k] == K_CLR) shadow[k][m_t[k]] = '0;
               m_t[k]++;
               if (m_t[k] == m_len[k]) begin
                  m_active[k] = 1'b0;
                  case (m_kind[k])
                     K_RD: begin e_rvalid[k] = 1'b1; e_rdata[k] = m_rval[k]; end
                     K_ERR: begin e_done[k] = 1'b1; e_err[k] = 1'b1; end
                     default: e_done[k] = 1'b1;
                  endcase
               end
            end else begin
               if (core_we && !halt && core_rd != 0) shadow[k][core_rd] = core_data;
               if (dbg_valid && halt) begin
                  m_active[k] = 1'b1;
                  m_t[k]      = 1;
                  m_addr[k]   = dbg_addr;
                  m_wdata[k]  = dbg_wdata;
                  m_rval[k]   = shadow[k][dbg_addr];
                  if (dbg_cmd == 2'b11 || int'(dbg_addr) >= size_of(k)) begin
                     m_kind[k] = K_ERR; m_len[k] = 2;
                  end else if (dbg_cmd == 2'b00) begin
                     m_kind[k] = K_RD;  m_len[k] = 3;
                  end else if (dbg_cmd == 2'b01) begin
                     m_kind[k] = K_WR;  m_len[k] = 2;
                  end else begin
                     m_kind[k] = K_CLR; m_len[k] = size_of(k);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, k, $time, act, exp);
      end
   endtask

   // Per-cycle compare against the model, sampled mid-cycle.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         chk(k, "ready",  32'(o_ready[k]),  32'(!m_active[k] && halt));
         chk(k, "rvalid", 32'(o_rvalid[k]), 32'(e_rvalid[k]));
         chk(k, "done",   32'(o_done[k]),   32'(e_done[k]));
         chk(k, "err",    32'(o_err[k]),    32'(e_err[k]));
         chk(k, "rdata",  o_rdata[k],       e_rdata[k]);
         if (!m_active[k]) begin
            chk(k, "pt_re",   32'(rf_re[k]),  32'(core_re));
            chk(k, "pt_we",   32'(rf_we[k]),  32'(core_we && !halt));
            chk(k, "pt_rs1",  32'(rf_rs1[k]), 32'(core_rs1));
            chk(k, "pt_rs2",  32'(rf_rs2[k]), 32'(core_rs2));
            chk(k, "pt_rd",   32'(rf_rd[k]),  32'(core_rd));
            chk(k, "pt_data", rf_data[k],     core_data);
         end else begin
            case (m_kind[k])
               K_RD: begin
                  chk(k, "rd_re", 32'(rf_re[k]), 32'(m_t[k] == 1));
                  chk(k, "rd_we", 32'(rf_we[k]), 32'd0);
                  if (m_t[k] == 1) begin
                     chk(k, "rd_rs1", 32'(rf_rs1[k]), 32'(m_addr[k]));
                     chk(k, "rd_rs2", 32'(rf_rs2[k]), 32'(m_addr[k]));
                  end
               end
               K_WR: begin
                  chk(k, "wr_re",   32'(rf_re[k]), 32'd0);
                  chk(k, "wr_we",   32'(rf_we[k]), 32'd1);
                  chk(k, "wr_rd",   32'(rf_rd[k]), 32'(m_addr[k]));
                  chk(k, "wr_data", rf_data[k],    m_wdata[k]);
               end
               K_CLR: begin
                  chk(k, "clr_re",   32'(rf_re[k]), 32'd0);
                  chk(k, "clr_we",   32'(rf_we[k]), 32'd1);
                  chk(k, "clr_rd",   32'(rf_rd[k]), 32'(m_t[k]));
                  chk(k, "clr_data", rf_data[k],    32'd0);
               end
               default: begin
                  chk(k, "err_re", 32'(rf_re[k]), 32'd0);
                  chk(k, "err_we", 32'(rf_we[k]), 32'd0);
               end
            endcase
         end
      end
   end

   // ---------------- directed command helper ----------------
   // Called at posedge+1; returns at posedge+1. lat counts cycles after the accept edge.
   task automatic do_cmd(input int k, input logic [1:0] cmd, input logic [4:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                         output logic err, output int we_cnt, output int re_cnt,
                         output bit rdy_low, output logic rdy_pulse);
      int  n;
      bit  seen;
      n = 0;
      lat = 0; rdata = '0; err = 1'b0; we_cnt = 0; re_cnt = 0; rdy_low = 1'b1; rdy_pulse = 1'b0;
      while (!o_ready[k] && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (!o_ready[k]) begin
         errors++; checks++;
         $display("FAIL wait_ready[%0d]: ready stayed %b, required 1", k, o_ready[k]);
         return;
      end
      dbg_valid = 1'b1; dbg_cmd = cmd; dbg_addr = addr; dbg_wdata = wd;
      @(posedge clk); #1;
      dbg_valid = 1'b0; dbg_cmd = 2'($urandom); dbg_addr = 5'($urandom); dbg_wdata = $urandom;
      seen = 1'b0;
      while (!seen && lat < 100) begin
         @(negedge clk);
         lat++;
         if (rf_we[k]) we_cnt++;
         if (rf_re[k]) re_cnt++;
         if (o_rvalid[k] || o_done[k]) begin
            seen = 1'b1; rdata = o_rdata[k]; err = o_err[k]; rdy_pulse = o_ready[k];
         end else if (o_ready[k]) begin
            rdy_low = 1'b0;
         end
      end
      if (!seen) begin
         errors++; checks++;
         $display("FAIL completion[%0d]: no pulse within %0d cycles, required one", k, lat);
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pre(int i);
      return 32'hA5A50000 | 32'(i);
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, wc, rc, n;
      logic [31:0] rd;
      logic er, rp;
      bit rl;

      rstn = 1'b0; halt = 1'b1;
      core_rs1 = '0; core_rs2 = '0; core_rd = '0; core_re = 1'b0; core_we = 1'b0; core_data = '0;
      dbg_valid = 1'b0; dbg_cmd = '0; dbg_addr = '0; dbg_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk(0, "rst_ready",  32'(o_ready[0]),  32'd1);
      chk(0, "rst_rvalid", 32'(o_rvalid[0]), 32'd0);
      chk(0, "rst_rdata",  o_rdata[0],       32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // write r5 then read it back
      do_cmd(0, 2'b01, 5'd5, 32'hDEADBEEF, lat, rd, er, wc, rc, rl, rp);
      chk(0, "wr5_lat", 32'(lat), 32'd2);
      chk(0, "wr5_err", 32'(er),  32'd0);
      chk(0, "wr5_ready_at_done", 32'(rp), 32'd1);
      do_cmd(0, 2'b00, 5'd5, 32'h0, lat, rd, er, wc, rc, rl, rp);
      chk(0, "rd5_lat",  32'(lat), 32'd3);
      chk(0, "rd5_data", rd,       32'hDEADBEEF);
      $display("txn write/read r5: lat=%0d data=%h", lat, rd);

      // r0 is hardwired to zero
      do_cmd(0, 2'b01, 5'd0, 32'h00001234, lat, rd, er, wc, rc, rl, rp);
      chk(0, "wr0_err", 32'(er), 32'd0);
      do_cmd(0, 2'b00, 5'd0, 32'h0, lat, rd, er, wc, rc, rl, rp);
      chk(0, "rd0_data", rd, 32'd0);
      $display("txn write/read r0: data=%h", rd);

      // clear-all
      do_cmd(0, 2'b01, 5'd1, 32'h1, lat, rd, er, wc, rc, rl, rp);
      do_cmd(0, 2'b01, 5'd31, 32'hFFFFFFFF, lat, rd, er, wc, rc, rl, rp);
      do_cmd(0, 2'b10, 5'd0, 32'h0, lat, rd, er, wc, rc, rl, rp);
      chk(0, "clr_lat",      32'(lat), 32'd32);
      chk(0, "clr_we_cnt",   32'(wc),  32'd31);
      chk(0, "clr_rdy_low",  32'(rl),  32'd1);
      chk(0, "clr_err",      32'(er),  32'd0);
      $display("txn clear-all: lat=%0d writes=%0d", lat, wc);
      do_cmd(0, 2'b00, 5'd1, 32'h0, lat, rd, er, wc, rc, rl, rp);
      chk(0, "clr_r1", rd, 32'd0);
      do_cmd(0, 2'b00, 5'd31, 32'h0, lat, rd, er, wc, rc, rl, rp);
      chk(0, "clr_r31", rd, 32'd0);

      // running core: no accept, writeback passes through
      halt = 1'b0; dbg_valid = 1'b1; dbg_cmd = 2'b00; dbg_addr = 5'd7;
      core_we = 1'b1; core_rd = 5'd7; core_data = 32'h55;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk(0, "run_ready", 32'(o_ready[0]), 32'd0);
         @(posedge clk); #1;
         core_we = 1'b0;
      end
      halt = 1'b1;
      do_cmd(0, 2'b00, 5'd7, 32'h0, lat, rd, er, wc, rc, rl, rp);
      chk(0, "core_r7_lat",  32'(lat), 32'd3);
      chk(0, "core_r7_data", rd,       32'h55);
      $display("txn core write r7 then debug read: data=%h", rd);

      // reset in the middle of clear-all
      for (int i = 1; i < 32; i++) do_cmd(0, 2'b01, 5'(i), pre(i), lat, rd, er, wc, rc, rl, rp);
      dbg_valid = 1'b1; dbg_cmd = 2'b10; dbg_addr = 5'd0;
      @(posedge clk); #1;
      dbg_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!(rf_we[0] && rf_rd[0] == 5'd10) && n < 100);
      if (n >= 100) begin
         errors++; checks++;
         $display("FAIL clr_reach10: counter never reached 10 (rd=%0d)", rf_rd[0]);
      end
      #1 rstn = 1'b0;
      #1;
      chk(0, "mid_rst_rvalid", 32'(o_rvalid[0]), 32'd0);
      chk(0, "mid_rst_done",   32'(o_done[0]),   32'd0);
      chk(0, "mid_rst_err",    32'(o_err[0]),    32'd0);
      chk(0, "mid_rst_rdata",  o_rdata[0],       32'd0);
      chk(0, "mid_rst_ready",  32'(o_ready[0]),  32'd1);
      chk(0, "mid_rst_we",     32'(rf_we[0]),    32'd0);
      @(negedge clk); #1 rstn = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i < 32; i++) begin
         do_cmd(0, 2'b00, 5'(i), 32'h0, lat, rd, er, wc, rc, rl, rp);
         chk(0, "partial_clr", rd, (i < 10) ? 32'd0 : pre(i));
      end
      $display("txn reset mid-clear: r9=0 expected, r10..r31 preserved");

      // illegal command and out-of-range address on the 16-register build
      do_cmd(1, 2'b11, 5'd3, 32'h0, lat, rd, er, wc, rc, rl, rp);
      chk(1, "ill_lat", 32'(lat), 32'd2);
      chk(1, "ill_err", 32'(er),  32'd1);
      chk(1, "ill_acc", 32'(wc + rc), 32'd0);
      do_cmd(1, 2'b00, 5'd20, 32'h0, lat, rd, er, wc, rc, rl, rp);
      chk(1, "oob_lat", 32'(lat), 32'd2);
      chk(1, "oob_err", 32'(er),  32'd1);
      chk(1, "oob_acc", 32'(wc + rc), 32'd0);
      $display("txn illegal/out-of-range on 16-entry build: err=%0b lat=%0d", er, lat);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         halt      = ($urandom_range(0, 3) != 0);
         core_rs1  = 5'($urandom); core_rs2 = 5'($urandom); core_rd = 5'($urandom);
         core_re   = 1'($urandom); core_we  = ($urandom_range(0, 2) == 0);
         core_data = $urandom;
         dbg_valid = ($urandom_range(0, 2) == 0);
         dbg_cmd   = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 3) == 3 ? 3 : $urandom_range(0, 1));
         dbg_addr  = 5'($urandom);
         dbg_wdata = $urandom;
         if ($urandom_range(0, 499) == 0) rstn = 1'b0;
         else rstn = 1'b1;
         @(posedge clk); #1;
      end
      rstn = 1'b1;
      dbg_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
